// File: rtl/bg_pkg.sv
// Shared types, constants and address helpers for the background fetch engine.
package bg_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MAP, S_PLANE, S_WAIT} fetch_state_e;

  localparam int TILE_W      = 8;
  localparam int MAP_W       = 32;
  localparam int XT_W        = $clog2(MAP_W);
  localparam int SHIFT_W     = 2 * TILE_W;
  localparam int CNT_W       = $clog2(SHIFT_W + 1);
  localparam int MAP_LOW_W   = 11;  // {map_sel, row[4:0], col[4:0]}; the rest is all ones
  localparam int DATA_CORE_W = 12;  // tile-data address before the plane field

  // Signed mode places idx 0..127 at 0x1000.. and 128..255 at 0x0800.., i.e.
  // base 0x1000 plus the sign-extended index (in units of the core field).
  function automatic logic [15:0] data_addr(input logic       dsel,
                                            input logic [7:0] idx,
                                            input logic [2:0] row,
                                            input logic [3:0] p,
                                            input int         pb);
    logic [DATA_CORE_W-1:0] core;
    core = dsel ? {1'b0, idx, row} : {~idx[7], idx[7], idx[6:0], row};
    return ({4'b0, core} << pb) | {12'b0, p};
  endfunction

endpackage

// File: rtl/bg_fetch_pipe_if.sv
// Control, VRAM and pixel-stream signals of the background engine.
interface bg_fetch_pipe_if #(
  parameter int PLANES = 2,
  parameter int ADDR_W = 12 + ((PLANES > 1) ? $clog2(PLANES) : 1)
);
  logic              lcd_en;
  logic              line_start;
  logic [7:0]        v;
  logic [7:0]        scx;
  logic [7:0]        scy;
  logic              map_sel;
  logic              data_sel;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack;
  logic [7:0]        vram_rdata;
  logic              pix_ready;
  logic              pix_valid;
  logic [PLANES-1:0] pix_out;
  logic              busy;

  modport master (
    input  lcd_en, line_start, v, scx, scy, map_sel, data_sel,
           vram_ack, vram_rdata, pix_ready,
    output vram_req, vram_addr, pix_valid, pix_out, busy
  );

  modport slave (
    output lcd_en, line_start, v, scx, scy, map_sel, data_sel,
           vram_ack, vram_rdata, pix_ready,
    input  vram_req, vram_addr, pix_valid, pix_out, busy
  );
endinterface

// File: rtl/bg_plane_shifter.sv
// One bitplane shifter: MSB-first output, byte load placed right behind the
// pixels still queued after this cycle's shift.
module bg_plane_shifter
  import bg_pkg::*;
(
  input  logic             clkpipe,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_pop,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_pos,
  input  logic [7:0]       i_byte,
  output logic             o_msb
);
  logic [SHIFT_W-1:0] r_sh;
  logic [SHIFT_W-1:0] w_shifted, w_mask, w_data, w_nxt;

  always_comb begin
    w_shifted = i_pop ? {r_sh[SHIFT_W-2:0], 1'b0} : r_sh;
    w_mask    = {8'hFF, 8'h00} >> i_pos;
    w_data    = {i_byte, 8'h00} >> i_pos;
    w_nxt     = i_load ? ((w_shifted & ~w_mask) | w_data) : w_shifted;
  end

  always_ff @(posedge clkpipe or posedge reset) begin
    if (reset)      r_sh <= '0;
    else if (i_clr) r_sh <= '0;
    else            r_sh <= w_nxt;
  end

  assign o_msb = r_sh[SHIFT_W-1];

endmodule

// File: rtl/bg_fetch_pipe.sv
// Background pixel engine: scrolled tile-map / tile-data fetch over a req/ack
// VRAM port, feeding PLANES bitplane shifters that stream pixels to the mixer.
module bg_fetch_pipe
  import bg_pkg::*;
#(
  parameter int PLANES = 2
) (
  input logic             clkpipe,
  input logic             reset,
  bg_fetch_pipe_if.master bus
);
  localparam int PLANE_BITS = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int ADDR_W     = 12 + PLANE_BITS;

  fetch_state_e r_state, w_state_nxt;

  logic                       r_req;
  logic [ADDR_W-1:0]          r_addr;
  logic [PLANE_BITS-1:0]      r_p;
  logic [7:0]                 r_idx;
  logic [7:0]                 r_ybg;
  logic [XT_W-1:0]            r_xtile;
  logic [2:0]                 r_discard;
  logic [CNT_W-1:0]           r_count;
  logic [PLANES-1:0][7:0]     r_bytes;

  logic                       w_abort, w_start, w_fetch, w_acked, w_last_plane;
  logic                       w_valid, w_disc_pop, w_pop, w_load;
  logic [CNT_W-1:0]           w_rem;
  logic [ADDR_W-1:0]          w_map_addr, w_data_addr;
  logic [PLANES-1:0]          w_pix;

  assign w_abort      = !bus.lcd_en;
  assign w_start      = bus.lcd_en && bus.line_start;
  assign w_fetch      = (r_state == S_MAP) || (r_state == S_PLANE);
  assign w_acked      = w_fetch && r_req && bus.vram_ack;
  assign w_last_plane = (r_p == PLANE_BITS'(PLANES - 1));

  // Fine-X discard drains the shifter without the mixer seeing those pixels.
  assign w_valid      = (r_count != '0) && (r_discard == '0);
  assign w_disc_pop   = (r_discard != '0) && (r_count != '0);
  assign w_pop        = (bus.pix_ready && w_valid) || w_disc_pop;
  assign w_rem        = r_count - CNT_W'(w_pop);
  assign w_load       = (r_state == S_WAIT) && (w_rem <= CNT_W'(TILE_W)) && !w_abort && !w_start;

  assign w_map_addr  = {{(ADDR_W-MAP_LOW_W){1'b1}}, bus.map_sel, r_ybg[7:3], r_xtile};
  assign w_data_addr = ADDR_W'(data_addr(bus.data_sel, r_idx, r_ybg[2:0], 4'(r_p), PLANE_BITS));

  always_ff @(posedge clkpipe or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort)      w_state_nxt = S_IDLE;
    else if (w_start) w_state_nxt = S_MAP;
    else begin
      case (r_state)
        S_MAP:   if (w_acked) w_state_nxt = S_PLANE;
        S_PLANE: if (w_acked && w_last_plane) w_state_nxt = S_WAIT;
        S_WAIT:  if (w_load) w_state_nxt = S_MAP;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Request rises the cycle after entering a fetch state and drops the cycle
  // after ack, giving a one-cycle gap between back-to-back reads.
  always_ff @(posedge clkpipe or posedge reset) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_p       <= '0;
      r_idx     <= '0;
      r_ybg     <= '0;
      r_xtile   <= '0;
      r_discard <= '0;
      r_count   <= '0;
      r_bytes   <= '0;
    end else if (w_abort) begin
      r_req     <= 1'b0;
      r_p       <= '0;
      r_discard <= '0;
      r_count   <= '0;
    end else if (w_start) begin
      r_req     <= 1'b0;
      r_p       <= '0;
      r_discard <= bus.scx[2:0];
      r_xtile   <= bus.scx[7:3];
      r_ybg     <= bus.v + bus.scy;
      r_count   <= '0;
    end else begin
      if (w_fetch) begin
        if (!r_req) begin
          r_req  <= 1'b1;
          r_addr <= (r_state == S_MAP) ? w_map_addr : w_data_addr;
        end else if (bus.vram_ack) begin
          r_req <= 1'b0;
          if (r_state == S_MAP) r_idx <= bus.vram_rdata;
          else begin
            for (int k = 0; k < PLANES; k++)
              if (int'(r_p) == k) r_bytes[k] <= bus.vram_rdata;
            r_p <= w_last_plane ? '0 : r_p + 1'b1;
          end
        end
      end
      if (w_load)     r_xtile   <= r_xtile + 1'b1;
      if (w_disc_pop) r_discard <= r_discard - 1'b1;
      r_count <= w_rem + (w_load ? CNT_W'(TILE_W) : '0);
    end
  end

  for (genvar gp = 0; gp < PLANES; gp++) begin : g_plane
    bg_plane_shifter u_sh (
      .clkpipe (clkpipe),
      .reset   (reset),
      .i_clr   (w_abort || w_start),
      .i_pop   (w_pop),
      .i_load  (w_load),
      .i_pos   (w_rem),
      .i_byte  (r_bytes[gp]),
      .o_msb   (w_pix[gp])
    );
  end

  assign bus.vram_req  = r_req;
  assign bus.vram_addr = r_addr;
  assign bus.pix_valid = w_valid;
  assign bus.pix_out   = w_pix;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bg_fetch_pipe.sv
// Bench for bg_fetch_pipe: VRAM model, per-line pixel/address model and directed lines.
module tb_bg_fetch_pipe;
  localparam int PLANES = 2;
  localparam int PB     = 1;
  localparam int AW     = 12 + PB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bg_fetch_pipe_if #(.PLANES(PLANES)) bus ();
  bg_fetch_pipe #(.PLANES(PLANES)) dut (.clkpipe(clk), .reset(rst), .bus(bus));

  logic [7:0] mem [0:(1<<AW)-1];
  int lat = 0, wcnt = 0;
  int errors = 0, checks = 0;
  int cyc = 0, rdy_pat = 0;
  bit chk_on = 0, track_bub = 0, live = 0;
  int bubbles = 0, n_pix = 0, n_sa = 0, n_sp = 0;
  int seen_addr [0:7];
  int seen_pix [0:15];
  int exp_addr [$];
  int exp_pix [$];
  logic prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int map_a(input int msel, input int yb, input int t);
    return ((1 << (AW-11)) - 1) * 2048 + msel * 1024 + (yb / 8) * 32 + t;
  endfunction

  function automatic int data_a(input int dsel, input int idx, input int row, input int p);
    int sidx;
    sidx = (idx >= 128) ? idx - 256 : idx;
    if (dsel != 0) return (idx * 8 + row) * (1 << PB) + p;
    return ((256 + sidx) * 8 + row) * (1 << PB) + p;
  endfunction

  task automatic build_line(input int sx, input int sy, input int vl, input int msel,
                            input int dsel, input int ntiles);
    int yb, row, t, ma, idx, x, pix;
    exp_addr.delete(); exp_pix.delete();
    yb = (vl + sy) & 255; row = yb & 7;
    for (int k = 0; k < ntiles; k++) begin
      t = ((sx >> 3) + k) % 32;
      ma = map_a(msel, yb, t);
      exp_addr.push_back(ma);
      idx = int'(mem[ma]);
      for (int p = 0; p < PLANES; p++) exp_addr.push_back(data_a(dsel, idx, row, p));
    end
    for (int i = 0; i < ntiles * 8 - (sx & 7); i++) begin
      x = (sx + i) & 255;
      idx = int'(mem[map_a(msel, yb, x >> 3)]);
      pix = 0;
      for (int p = 0; p < PLANES; p++)
        if (mem[data_a(dsel, idx, row, p)][7 - (x & 7)]) pix |= (1 << p);
      exp_pix.push_back(pix);
    end
    n_sa = 0; n_sp = 0; n_pix = 0; live = 0; bubbles = 0;
  endtask

  // VRAM: ack after `lat` wait cycles, data valid with ack
  always @(negedge clk) begin
    if (bus.vram_req) begin
      if (wcnt >= lat) begin
        bus.vram_ack = 1'b1;
        bus.vram_rdata = mem[bus.vram_addr];
      end else begin
        bus.vram_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.vram_ack = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (bus.vram_req && !prev_req) begin
        if (n_sa < 8) seen_addr[n_sa] = int'(bus.vram_addr);
        n_sa++;
        if (exp_addr.size() > 0) chk("vram_addr", 32'(bus.vram_addr), 32'(exp_addr.pop_front()));
      end
      if (bus.vram_req && prev_req) chk("addr_hold", 32'(bus.vram_addr), 32'(prev_addr));
      if (bus.pix_valid && bus.pix_ready) begin
        if (n_sp < 16) seen_pix[n_sp] = int'(bus.pix_out);
        n_sp++;
        if (exp_pix.size() > 0) begin
          chk("pix_out", 32'(bus.pix_out), 32'(exp_pix.pop_front()));
          n_pix++;
        end
      end
      if (track_bub) begin
        if (bus.pix_valid) live = 1;
        else if (live && bus.pix_ready) bubbles++;
      end
    end
    prev_req = bus.vram_req;
    prev_addr = bus.vram_addr;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_pat)
        0: bus.pix_ready = 1'b1;
        1: bus.pix_ready = 1'b0;
        default: bus.pix_ready = (cyc % 3) != 0;
      endcase
    end
  endtask

  task automatic start_line(input int sx, input int sy, input int vl, input int msel, input int dsel);
    bus.scx = 8'(sx); bus.scy = 8'(sy); bus.v = 8'(vl);
    bus.map_sel = 1'(msel); bus.data_sel = 1'(dsel);
    bus.line_start = 1'b1; chk_on = 0;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    build_line(sx, sy, vl, msel, dsel, 12);
    chk_on = 1;
  endtask

  initial begin
    int reqcnt, chg, found;
    logic [PLANES-1:0] po;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'((a * 73 + 29) & 255);
    bus.lcd_en = 1'b1; bus.line_start = 1'b0; bus.v = '0; bus.scx = '0; bus.scy = '0;
    bus.map_sel = 1'b0; bus.data_sel = 1'b1; bus.pix_ready = 1'b0;
    bus.vram_ack = 1'b0; bus.vram_rdata = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_req", 32'(bus.vram_req), 0);
    chk("rst_valid", 32'(bus.pix_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.vram_addr), 0);
    rst = 1'b0;
    step(3);
    chk("idle_busy", 32'(bus.busy), 0);

    // A: basic line, zero-latency ack, continuous ready
    mem[13'h1800] = 8'h05; mem[13'h0050] = 8'hF0; mem[13'h0051] = 8'h0F;
    rdy_pat = 0; track_bub = 1;
    start_line(0, 0, 0, 0, 1);
    step(60);
    chk("A_addr0", 32'(seen_addr[0]), 32'h1800);
    chk("A_addr1", 32'(seen_addr[1]), 32'h0050);
    chk("A_addr2", 32'(seen_addr[2]), 32'h0051);
    for (int i = 0; i < 8; i++) chk("A_pix", 32'(seen_pix[i]), (i < 4) ? 32'd1 : 32'd2);
    chk("A_bubbles", 32'(bubbles), 0);
    chk("A_npix", 32'(n_pix >= 40), 1);

    // B: mixer stall, then release
    rdy_pat = 1;
    step(10);
    po = bus.pix_out; reqcnt = 0; chg = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.vram_req) reqcnt++;
      if (bus.pix_out !== po) chg++;
    end
    chk("B_no_req", 32'(reqcnt), 0);
    chk("B_pix_hold", 32'(chg), 0);
    chk("B_valid", 32'(bus.pix_valid), 1);
    chk("B_busy", 32'(bus.busy), 1);
    rdy_pat = 0; bubbles = 0;
    step(40);
    chk("B_bubbles", 32'(bubbles), 0);
    track_bub = 0;

    // C: signed tile-data mode, row 3
    mem[13'h1800] = 8'h80; mem[13'h1801] = 8'h7F;
    rdy_pat = 2;
    start_line(0, 0, 3, 0, 0);
    step(40);
    chk("C_map0", 32'(seen_addr[0]), 32'h1800);
    chk("C_data80", 32'(seen_addr[1]), 32'h0806);
    chk("C_map1", 32'(seen_addr[3]), 32'h1801);
    chk("C_data7F", 32'(seen_addr[4]), 32'h17F6);
    chk("C_npix", 32'(n_pix >= 15), 1);

    // D: fine scroll 5 discards five pixels
    mem[13'h1800] = 8'h05; mem[13'h0050] = 8'h04; mem[13'h0051] = 8'h00;
    rdy_pat = 0;
    start_line(5, 0, 0, 0, 1);
    step(30);
    chk("D_map0", 32'(seen_addr[0]), 32'h1800);
    chk("D_pix0", 32'(seen_pix[0]), 1);
    chk("D_pix1", 32'(seen_pix[1]), 0);
    chk("D_pix2", 32'(seen_pix[2]), 0);

    // E: xtile wraps 31 -> 0
    start_line(8'hFD, 0, 0, 0, 1);
    step(30);
    chk("E_map31", 32'(seen_addr[0]), 32'h181F);
    chk("E_map0", 32'(seen_addr[3]), 32'h1800);
    chk("E_npix", 32'(n_pix >= 15), 1);

    // H: slow VRAM, alternate map, scrolled both ways, signed mode
    lat = 3; rdy_pat = 2;
    start_line(8'h13, 8'h25, 8'h40, 1, 0);
    step(120);
    chk("H_npix", 32'(n_pix >= 20), 1);
    lat = 0; rdy_pat = 0;

    // F: line_start while plane 1 is being acked
    start_line(0, 0, 0, 0, 1);
    step(20);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(1);
      if (bus.vram_req && bus.vram_addr[0]) found = 1;
    end
    chk("F_found", 32'(found), 1);
    bus.scx = 8'h10; bus.line_start = 1'b1; chk_on = 0;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    chk("F_req", 32'(bus.vram_req), 0);
    chk("F_valid", 32'(bus.pix_valid), 0);
    chk("F_busy", 32'(bus.busy), 1);
    build_line(8'h10, 0, 0, 0, 1, 12);
    chk_on = 1;
    step(30);
    chk("F_map", 32'(seen_addr[0]), 32'h1802);
    chk("F_npix", 32'(n_pix >= 10), 1);

    // G: lcd_en low wins over line_start
    chk_on = 0;
    bus.lcd_en = 1'b0; bus.line_start = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    chk("G_busy", 32'(bus.busy), 0);
    chk("G_req", 32'(bus.vram_req), 0);
    chk("G_valid", 32'(bus.pix_valid), 0);
    bus.lcd_en = 1'b1;
    step(3);
    chk("G_stay_idle", 32'(bus.busy), 0);

    // Reset asserted while a request is outstanding
    lat = 3;
    start_line(0, 0, 0, 0, 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1);
      if (bus.vram_req) found = 1;
    end
    chk("R_found", 32'(found), 1);
    chk_on = 0;
    rst = 1'b1; #1;
    chk("R_req", 32'(bus.vram_req), 0);
    chk("R_valid", 32'(bus.pix_valid), 0);
    chk("R_busy", 32'(bus.busy), 0);
    chk("R_addr", 32'(bus.vram_addr), 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("R_idle", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
